// File: rtl/alu_pkg.sv
// Shared ALU-cluster definitions: default widths, shift op codes and scheduler FSM states.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_SHL_A = 3'b000;
  localparam logic [OP_W-1:0] OP_SHR_A = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL_B = 3'b010;
  localparam logic [OP_W-1:0] OP_SHR_B = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  // Codes with the top bit set are reserved and produce a zero result.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Request/response bundle between the two issuing stages and the shift scheduler.
// SHIFT_SCHED_ERR_EN adds the per-requester illegal-op flags.
interface shift_sched_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [AMT_W-1:0]  req0_amt;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [AMT_W-1:0]  req1_amt;
  logic [OP_W-1:0]   req1_op;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;

`ifdef SHIFT_SCHED_ERR_EN
  logic              rsp0_err;
  logic              rsp1_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_amt, req0_op,
    output req1_valid, req1_a, req1_b, req1_amt, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_err,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_amt, req0_op,
    input  req1_valid, req1_a, req1_b, req1_amt, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_err,
    input  rsp0_ready, rsp1_ready
  );
`else
  modport master (
    output req0_valid, req0_a, req0_b, req0_amt, req0_op,
    output req1_valid, req1_a, req1_b, req1_amt, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result,
    input  rsp1_valid, rsp1_result,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_amt, req0_op,
    input  req1_valid, req1_a, req1_b, req1_amt, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result,
    output rsp1_valid, rsp1_result,
    input  rsp0_ready, rsp1_ready
  );
`endif

endinterface

// File: rtl/shift.sv
// Combinational 32-bit logical shifter: shifts operand a or b left/right by amt, zero result for reserved ops.
module shift
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [AMT_W-1:0]  amt,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_SHL_A: y = a << amt;
      OP_SHR_A: y = a >> amt;
      OP_SHL_B: y = b << amt;
      OP_SHR_B: y = b >> amt;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one shift unit between two requesters, one transaction at a time.
// SHIFT_SCHED_ERR_EN adds rsp0_err/rsp1_err flagging reserved op codes.
module shift_sched
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  shift_sched_if.slave    bus,
  output logic            busy
);

  state_e            state;
  logic              ptr;
  logic              owner;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [AMT_W-1:0]  amt_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] result_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] shift_y;
  logic              grant0_c;
  logic              grant1_c;
  logic              rsp_hs_c;

  // Pointer's requester wins; the other only when the pointer's side is idle.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == IDLE) begin
      if (ptr == 1'b0) begin
        grant0_c = bus.req0_valid;
        grant1_c = bus.req1_valid & ~bus.req0_valid;
      end else begin
        grant1_c = bus.req1_valid;
        grant0_c = bus.req0_valid & ~bus.req1_valid;
      end
    end
  end

  assign rsp_hs_c = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.req0_ready  = grant0_c;
  assign bus.req1_ready  = grant1_c;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_result = result_q;
  assign bus.rsp1_result = result_q;

  shift u_shift (
    .a   (a_q),
    .b   (b_q),
    .amt (amt_q),
    .op  (op_q),
    .y   (shift_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      amt_q        <= '0;
      op_q         <= '0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c | grant1_c) begin
            a_q   <= grant1_c ? bus.req1_a   : bus.req0_a;
            b_q   <= grant1_c ? bus.req1_b   : bus.req0_b;
            amt_q <= grant1_c ? bus.req1_amt : bus.req0_amt;
            op_q  <= grant1_c ? bus.req1_op  : bus.req0_op;
            owner <= grant1_c;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= shift_y;
          rsp0_valid_q <= ~owner;
          rsp1_valid_q <= owner;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_hs_c) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            ptr          <= ~owner;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SCHED_ERR_EN
  logic rsp0_err_q;
  logic rsp1_err_q;

  // Error flag rides alongside the owner's valid and drops with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_err_q <= 1'b0;
      rsp1_err_q <= 1'b0;
    end else if (state == EXEC) begin
      rsp0_err_q <= ~owner & op_illegal(op_q);
      rsp1_err_q <= owner & op_illegal(op_q);
    end else if (rsp_hs_c) begin
      rsp0_err_q <= 1'b0;
      rsp1_err_q <= 1'b0;
    end
  end

  assign bus.rsp0_err = rsp0_err_q;
  assign bus.rsp1_err = rsp1_err_q;
`endif

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched: directed scenarios followed by randomized two-requester traffic.
`timescale 1ns/1ps
module tb_shift_sched;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  shift_sched_if bus ();

  shift_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          err;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: shifting expressed as multiplication/division by a power of two.
  function automatic exp_t model(input bit id, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] amt);
    exp_t e;
    longint unsigned pw = 1;
    longint unsigned src;
    for (int i = 0; i < int'(amt); i++) pw = pw * 2;
    src = (op == 3'd2 || op == 3'd3) ? 64'(b) : 64'(a);
    e.id  = id;
    e.err = (op >= 3'd4);
    if (op >= 3'd4)                    e.res = 32'd0;
    else if (op == 3'd0 || op == 3'd2) e.res = 32'(src * pw);
    else                               e.res = 32'(src / pw);
    return e;
  endfunction

  // Monitor: high-level model of one outstanding transaction plus round-robin pointer.
  bit m_out = 0;
  bit m_owner = 0;
  bit m_ptr = 0;
  bit just_rst = 0;
  int m_iss = 0;
  int cyc = 0;

  always @(negedge clk) begin
    logic er0, er1;
    logic [31:0] act;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_out = 0;
      m_ptr = 0;
      just_rst = 1;
    end else begin
      check("busy", 32'(busy), 32'(m_out));
      if (just_rst) begin
        check("rst_result0", bus.rsp0_result, 32'd0);
        check("rst_result1", bus.rsp1_result, 32'd0);
        just_rst = 0;
      end
      er0 = !m_out && bus.req0_valid && (m_ptr == 1'b0 || !bus.req1_valid);
      er1 = !m_out && bus.req1_valid && (m_ptr == 1'b1 || !bus.req0_valid);
      check("req0_ready", 32'(bus.req0_ready), 32'(er0));
      check("req1_ready", 32'(bus.req1_ready), 32'(er1));
      if (m_out && cyc >= m_iss + 2) begin
        check("rsp_valid_owner", 32'(m_owner ? bus.rsp1_valid : bus.rsp0_valid), 32'd1);
        check("rsp_valid_other", 32'(m_owner ? bus.rsp0_valid : bus.rsp1_valid), 32'd0);
        act = m_owner ? bus.rsp1_result : bus.rsp0_result;
        check("result", act, exp_q[0].res);
`ifdef SHIFT_SCHED_ERR_EN
        check("err_owner", 32'(m_owner ? bus.rsp1_err : bus.rsp0_err), 32'(exp_q[0].err));
        check("err_other", 32'(m_owner ? bus.rsp0_err : bus.rsp1_err), 32'd0);
`endif
        if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
          void'(exp_q.pop_front());
          m_out = 0;
          m_ptr = !m_owner;
        end
      end else begin
        check("rsp0_valid_quiet", 32'(bus.rsp0_valid), 32'd0);
        check("rsp1_valid_quiet", 32'(bus.rsp1_valid), 32'd0);
      end
      if (bus.req0_valid && bus.req0_ready) begin
        e = model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_amt);
        exp_q.push_back(e);
        m_out = 1; m_owner = 0; m_iss = cyc;
      end else if (bus.req1_valid && bus.req1_ready) begin
        e = model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_amt);
        exp_q.push_back(e);
        m_out = 1; m_owner = 1; m_iss = cyc;
      end
    end
  end

  // Stimulus side: per-cycle snapshot taken on the falling edge, inputs driven after the rising edge.
  bit hs0, hs1, got0, got1, rv0, rv1, rd0, rd1, bsy, e0, e1;
  logic [31:0] res0, res1;

  task automatic step();
    @(negedge clk);
    hs0  = bus.req0_valid & bus.req0_ready;
    hs1  = bus.req1_valid & bus.req1_ready;
    got0 = bus.rsp0_valid & bus.rsp0_ready;
    got1 = bus.rsp1_valid & bus.rsp1_ready;
    rv0  = bus.rsp0_valid;
    rv1  = bus.rsp1_valid;
    rd0  = bus.req0_ready;
    rd1  = bus.req1_ready;
    bsy  = busy;
    res0 = bus.rsp0_result;
    res1 = bus.rsp1_result;
`ifdef SHIFT_SCHED_ERR_EN
    e0 = bus.rsp0_err;
    e1 = bus.rsp1_err;
`else
    e0 = 0;
    e1 = 0;
`endif
    @(posedge clk);
    #1;
    if (hs0) bus.req0_valid = 1'b0;
    if (hs1) bus.req1_valid = 1'b0;
  endtask

  task automatic set_req(input bit id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] amt);
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_amt = amt; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_amt = amt; bus.req0_valid = 1'b1;
    end
  endtask

  task automatic wait_rsp(input bit id, input logic [31:0] exp_res, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(id ? got1 : got0) && n < 30);
    if (!(id ? got1 : got0)) begin
      total++; bad++;
      $display("FAIL %s: no response within %0d cycles", name, n);
    end else begin
      check(name, id ? res1 : res0, exp_res);
    end
  endtask

  task automatic wait_first_hs(output bit first1, input string name);
    int n = 0;
    first1 = 0;
    do begin
      step();
      n++;
    end while (!(hs0 | hs1) && n < 30);
    if (!(hs0 | hs1)) begin
      total++; bad++;
      $display("FAIL %s: no grant within %0d cycles", name, n);
    end else begin
      first1 = hs1;
    end
  endtask

  initial begin
    bit f1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_amt = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_amt = 0; bus.req1_op = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    step(); step();
    rst_n = 1'b1;
    step();
    check("reset_busy", 32'(bsy), 32'd0);
    check("reset_rsp0_valid", 32'(rv0), 32'd0);
    check("reset_rsp1_valid", 32'(rv1), 32'd0);
    check("reset_rsp0_result", res0, 32'd0);

    // Single request
    set_req(0, 3'b000, 32'h0000_0001, 32'h0, 5'd4);
    wait_rsp(0, 32'h0000_0010, "single_shl");

    // Contention: pointer at requester 1 now, so reset-style priority is checked after reset below;
    // here requester 1 wins first, then alternation.
    set_req(0, 3'b001, 32'h8000_0000, 32'h0, 5'd31);
    set_req(1, 3'b011, 32'h0, 32'h0000_00F0, 5'd4);
    wait_first_hs(f1, "contend_first");
    check("contend_first_is_req1", 32'(f1), 32'd1);
    wait_rsp(1, 32'h0000_000F, "contend_req1");
    wait_rsp(0, 32'h0000_0001, "contend_req0");
    set_req(0, 3'b000, 32'h0000_0003, 32'h0, 5'd2);
    set_req(1, 3'b010, 32'h0, 32'h0000_0005, 5'd1);
    wait_first_hs(f1, "alternate_first");
    check("alternate_first_is_req1", 32'(f1), 32'd1);
    wait_rsp(1, 32'h0000_000A, "alternate_req1");
    wait_rsp(0, 32'h0000_000C, "alternate_req0");

    // Backpressure on requester 1 with requester 0 waiting
    bus.rsp1_ready = 0;
    set_req(1, 3'b000, 32'h0000_0003, 32'h0, 5'd1);
    for (int n = 0; n < 30 && !rv1; n++) step();
    set_req(0, 3'b001, 32'h0000_0100, 32'h0, 5'd8);
    for (int n = 0; n < 5; n++) begin
      step();
      check("bp_valid", 32'(rv1), 32'd1);
      check("bp_result", res1, 32'h0000_0006);
      check("bp_busy", 32'(bsy), 32'd1);
      check("bp_ready0", 32'(rd0), 32'd0);
    end
    bus.rsp1_ready = 1;
    step();
    check("bp_release", 32'(got1), 32'd1);
    step();
    check("bp_idle_busy", 32'(bsy), 32'd0);
    check("bp_req0_granted", 32'(hs0), 32'd1);
    wait_rsp(0, 32'h0000_0001, "bp_req0");

    // Reserved op and amt=0 pass-through
    set_req(1, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    wait_rsp(1, 32'h0, "illegal_op");
`ifdef SHIFT_SCHED_ERR_EN
    check("illegal_err", 32'(e1), 32'd1);
`endif
    set_req(0, 3'b010, 32'h0, 32'hDEAD_BEEF, 5'd0);
    wait_rsp(0, 32'hDEAD_BEEF, "amt_zero");
`ifdef SHIFT_SCHED_ERR_EN
    check("legal_err", 32'(e0), 32'd0);
`endif

    // Reset while in EXEC discards the transaction and restores priority to requester 0
    set_req(0, 3'b000, 32'h0000_0001, 32'h0, 5'd1);
    wait_first_hs(f1, "rst_issue");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid_busy", 32'(bsy), 32'd0);
    check("rst_mid_rsp0", 32'(rv0), 32'd0);
    for (int n = 0; n < 4; n++) begin
      step();
      check("rst_mid_no_rsp", 32'(rv0 | rv1), 32'd0);
    end
    set_req(0, 3'b000, 32'h0000_0007, 32'h0, 5'd4);
    set_req(1, 3'b001, 32'h0000_0070, 32'h0, 5'd4);
    wait_first_hs(f1, "post_rst_first");
    check("post_rst_first_is_req0", 32'(f1), 32'd0);
    wait_rsp(0, 32'h0000_0070, "post_rst_req0");
    wait_rsp(1, 32'h0000_0007, "post_rst_req1");

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step();
      bus.rsp0_ready = ($urandom_range(0, 9) < 6);
      bus.rsp1_ready = ($urandom_range(0, 9) < 6);
      if (bus.req0_valid) begin
        if ($urandom_range(0, 29) == 0) bus.req0_valid = 1'b0;
      end else if ($urandom_range(0, 9) < 5) begin
        set_req(0, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      end
      if (bus.req1_valid) begin
        if ($urandom_range(0, 29) == 0) bus.req1_valid = 1'b0;
      end else if ($urandom_range(0, 9) < 5) begin
        set_req(1, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      end
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rsp0_ready = 1;
    bus.rsp1_ready = 1;
    for (int n = 0; n < 10; n++) step();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Two-requester scheduler that shares one 32-bit shift unit (left/right shift of operand a or b, 3-bit op select, 5-bit amount) between two clients.
- Arbitrates round-robin and registers the winning request's operands into the shared unit.
- Registers the result and returns it on a per-requester valid/ready response channel.
- Sits between the two issuing datapath stages and the shifter inside the ALU cluster.

Parameters:
- DATA_W, 32, operand/result width.
- AMT_W, 5, shift-amount width; must equal clog2(DATA_W).
- OP_W, 3, op-select width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a  in  DATA_W  operand a.
- req0_b  in  DATA_W  operand b.
- req0_amt  in  AMT_W  shift amount.
- req0_op  in  OP_W  op: 000 a<<amt, 001 a>>amt, 010 b<<amt, 011 b>>amt, others give result 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_amt, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_result  out  DATA_W  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_result: same as requester 0, for requester 1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - rsp*_valid = 0, rsp*_result = 0, busy = 0.
  - Operand, owner and result registers = 0.
  - Round-robin pointer = 0 (requester 0 has priority).
- IDLE:
  - Winner = the pointer's requester if its valid is high, else the other requester if its valid is high.
  - reqN_ready = 1 only for the winner; this is a combinational function of req*_valid and the pointer.
  - On handshake (valid & ready): capture a, b, amt, op and owner id, then go to EXEC.
  - With no valid request: stay in IDLE, all ready outputs 0.
- EXEC: exactly one cycle. Drive the captured operands into the shift unit, register its output into the result register, go to RESP.
- RESP:
  - rspOWNER_valid = 1; rsp*_result carries the result register (both result ports may show it; only the owner's valid is high).
  - Result is held stable until rspOWNER_ready = 1.
  - On that handshake: pointer moves to the non-owner, go to IDLE.
  - All req*_ready = 0 in EXEC and RESP.
- Latency and throughput:
  - Request handshake at cycle T gives rsp_valid at T+2.
  - Minimum issue interval is 3 cycles; no overlap between transactions.
- Arithmetic: logical shifts, zero fill, result truncated to DATA_W. amt=0 passes the operand through. Ops 100–111 give result 0 and are still a full transaction.
- Simultaneous requests: the pointer's requester wins. The loser keeps valid and payload stable (client obligation) and is served next. Under continuous contention service strictly alternates.
- A requester that drops valid before handshake is ignored. No error is raised.
- Reset in any state:
  - Next edge returns to IDLE with all reset values.
  - An in-flight transaction is discarded with no response.
  - Pointer returns to 0.
- Single requester active: it is served back-to-back every 3 cycles regardless of the pointer.

Optional Feature:
- Macro: SHIFT_SCHED_ERR_EN.
- When defined:
  - Adds outputs rsp0_err and rsp1_err (1 bit each), both reset to 0.
  - rspN_err is valid alongside rspN_valid and is 1 when the captured op is 100–111.
  - The result is still 0 in that case.
- When not defined: the err ports do not exist; illegal ops silently return 0.

Decomposition:
- Shared package (alu_pkg) holds:
  - Op-code constants: OP_SHL_A=3'b000, OP_SHR_A=3'b001, OP_SHL_B=3'b010, OP_SHR_B=3'b011.
  - The FSM state enum {IDLE, EXEC, RESP}.
  - The default widths.
- One sub-module: instantiate the team's existing combinational shift unit, module `shift`, as the shared datapath. The scheduler does not re-implement shifting.

Test Plan:
- Single request: req0 op=000, a=0x0000_0001, amt=4, handshake at T → rsp0_valid at T+2, rsp0_result=0x0000_0010; rsp1_valid stays 0.
- Contention after reset: req0 and req1 valid together (req0 op=001 a=0x8000_0000 amt=31; req1 op=011 b=0xF0 amt=4) → req0 served first with result 0x1; req1 served next with 0xF; a third round of both valid serves req0 again (alternation).
- Backpressure: hold rsp1_ready=0 for 5 cycles in RESP → rsp1_valid and rsp1_result stable, busy=1, both req*_ready=0; ready=1 → IDLE next cycle.
- Illegal op and boundaries:
  - req1 op=101 → result 0, rsp1_err=1 when SHIFT_SCHED_ERR_EN is defined.
  - op=010 with amt=0, b=0xDEAD_BEEF → 0xDEAD_BEEF.
- Reset mid-operation: assert rst_n=0 during EXEC → next cycle IDLE, busy=0, no rsp_valid ever issued for that request; a subsequent simultaneous pair is granted to req0.
